// File: rtl/mem_pkg.sv
// mem_pkg: shared RV32I load/store decode constants, fault encodings and FSM state for the MEM stage
package mem_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {FC_MISALIGN = 2'b00, FC_ILLEGAL = 2'b01, FC_TIMEOUT = 2'b10} fault_cause_t;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory request bus with active-low ready
interface mem_access_unit_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ready_n;
  logic [31:0]       mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_ready_n, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_ready_n, mem_rdata);
endinterface

// File: rtl/load_ext.sv
// load_ext: byte/half lane select by address offset with sign or zero extension
module load_ext import mem_pkg::*; (
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{offset, 3'b000} +: 8];
  assign h = rdata[{offset[1], 4'b0000} +: 16];
  always_comb begin
    data = funct3 == F3_B  ? {{24{b[7]}}, b} :
           funct3 == F3_BU ? {24'b0, b} :
           funct3 == F3_H  ? {{16{h[15]}}, h} :
           funct3 == F3_HU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store FSM holding a request until memory accepts it
// MEM_TIMEOUT_EN: abort a request after MAX_WAIT REQ cycles with a timeout fault
module mem_access_unit import mem_pkg::*; #(
  parameter int ADDR_W     = 32,
  parameter int MAX_WAIT   = 15,
  parameter int WAIT_CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  mem_access_unit_if.master mem,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_cause
);
  state_t state, state_n;
  logic is_ld, is_st, legal, misal, accept, bad, tmo, to_q, we_q;
  logic [1:0] off_q;
  logic [2:0] f3_q;
  logic [3:0] be, be_q;
  logic [31:0] wdata, wdata_q, ext;
  logic [ADDR_W-1:0] addr_q;
  if (2 ** WAIT_CNT_W <= MAX_WAIT) begin : g_bad_cfg
    $error("WAIT_CNT_W too narrow for MAX_WAIT");
  end
  assign is_ld  = opcode == OP_LOAD;
  assign is_st  = opcode == OP_STORE;
  assign legal  = is_ld ? funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU} : funct3 inside {F3_B, F3_H, F3_W};
  assign misal  = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign accept = state == IDLE && issue_valid && (is_ld || is_st) && legal && !misal;
  assign bad    = state == IDLE && issue_valid && (is_ld || is_st) && (!legal || misal);
  assign be     = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                  funct3[1:0] == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
  assign wdata  = !is_st ? 32'b0 :
                  funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                  funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
`ifdef MEM_TIMEOUT_EN
  logic [WAIT_CNT_W-1:0] wcnt;
  assign tmo = state == REQ && mem.mem_ready_n && wcnt == WAIT_CNT_W'(MAX_WAIT - 1);
  always_ff @(posedge clk) wcnt <= (rst || state != REQ) ? '0 : wcnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  load_ext u_ext (.rdata(mem.mem_rdata), .funct3(f3_q), .offset(off_q), .data(ext));
  always_comb begin
    state_n = state == IDLE ? (accept ? REQ : IDLE) :
              state == REQ  ? ((!mem.mem_ready_n || tmo) ? DONE : REQ) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      we_q      <= 1'b0;
      to_q      <= 1'b0;
      load_data <= '0;
    end else begin
      state <= state_n;
      to_q  <= tmo;
      if (accept) begin
        addr_q  <= {addr[ADDR_W-1:2], 2'b00};
        be_q    <= be;
        wdata_q <= wdata;
        f3_q    <= funct3;
        off_q   <= addr[1:0];
        we_q    <= is_st;
      end
      if (state == REQ && !mem.mem_ready_n && !we_q) load_data <= ext;
    end
  end
  assign mem.mem_req   = state == REQ;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;
  assign stall         = accept || state == REQ;
  assign done          = state == DONE;
  assign fault         = bad || (done && to_q);
  assign fault_cause   = !fault ? 2'b00 : (done && to_q) ? FC_TIMEOUT : !legal ? FC_ILLEGAL : FC_MISALIGN;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store/fault/reset vectors with hand-computed expectations
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic issue_valid = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic stall, done, fault;
  logic [31:0] load_data;
  logic [1:0] fault_cause;
  int n_vec = 0;
  int n_err = 0;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  mem_access_unit_if #(.ADDR_W(32)) bus ();
`ifdef MEM_TIMEOUT_EN
  mem_access_unit #(.ADDR_W(32), .MAX_WAIT(4), .WAIT_CNT_W(8)) dut (
`else
  mem_access_unit #(.ADDR_W(32)) dut (
`endif
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .opcode(opcode), .funct3(funct3),
    .addr(addr), .store_data(store_data), .mem(bus.master), .stall(stall),
    .load_data(load_data), .done(done), .fault(fault), .fault_cause(fault_cause)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic mem_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int waits,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic [31:0] exp_ld);
    @(negedge clk);
    issue_valid = 1'b1; opcode = op; funct3 = f3; addr = a; store_data = sd; bus.mem_ready_n = 1'b1;
    #1;
    chk("accept_stall", {31'b0, stall}, 32'd1);
    chk("accept_noreq", {31'b0, bus.mem_req}, 32'd0);
    @(negedge clk);
    issue_valid = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      bus.mem_ready_n = (i == waits) ? 1'b0 : 1'b1;
      bus.mem_rdata = rd;
      #1;
      chk("req", {31'b0, bus.mem_req}, 32'd1);
      chk("req_stall", {31'b0, stall}, 32'd1);
      chk("req_we", {31'b0, bus.mem_we}, {31'b0, op == ST});
      chk("req_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
      chk("req_be", {28'b0, bus.mem_be}, {28'b0, exp_be});
      chk("req_wdata", bus.mem_wdata, exp_wd);
      @(negedge clk);
    end
    bus.mem_ready_n = 1'b1;
    #1;
    chk("done", {31'b0, done}, 32'd1);
    chk("done_stall", {31'b0, stall}, 32'd0);
    chk("done_noreq", {31'b0, bus.mem_req}, 32'd0);
    chk("done_nofault", {31'b0, fault}, 32'd0);
    chk("load_data", load_data, exp_ld);
  endtask
  task automatic bad_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic exp_fault, input logic [1:0] exp_cause);
    @(negedge clk);
    issue_valid = 1'b1; opcode = op; funct3 = f3; addr = a;
    #1;
    chk("bad_fault", {31'b0, fault}, {31'b0, exp_fault});
    chk("bad_cause", {30'b0, fault_cause}, {30'b0, exp_cause});
    chk("bad_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    chk("bad_idle_noreq", {31'b0, bus.mem_req}, 32'd0);
    chk("bad_idle_nofault", {31'b0, fault}, 32'd0);
  endtask
  initial begin
    bus.mem_ready_n = 1'b1;
    bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_fault", {30'b0, fault_cause, fault}, 32'd0);
    chk("rst_load", load_data, 32'd0);
    chk("rst_bus", bus.mem_wdata | bus.mem_addr | {28'b0, bus.mem_be} | {31'b0, bus.mem_we}, 32'd0);
    rst = 1'b0;
    mem_op(LD, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h0, 32'hDEADBEEF);
    mem_op(LD, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 4'b1000, 32'h0, 32'hFFFFFF80);
    mem_op(LD, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 4'b1000, 32'h0, 32'h00000080);
    mem_op(LD, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0, 4'b1100, 32'h0, 32'hFFFF80FF);
    mem_op(LD, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 1, 4'b1100, 32'h0, 32'h000080FF);
    mem_op(LD, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 4'b0010, 32'h0, 32'h0000007F);
    mem_op(ST, 3'b001, 32'h006, 32'h0000ABCD, 32'h11111111, 3, 4'b1100, 32'hABCDABCD, 32'h0000007F);
    mem_op(ST, 3'b000, 32'h001, 32'h12345677, 32'h0, 0, 4'b0010, 32'h77777777, 32'h0000007F);
    mem_op(ST, 3'b010, 32'h008, 32'hCAFEF00D, 32'h0, 2, 4'b1111, 32'hCAFEF00D, 32'h0000007F);
    bad_op(LD, 3'b010, 32'h101, 1'b1, 2'b00);
    bad_op(ST, 3'b011, 32'h100, 1'b1, 2'b01);
    bad_op(LD, 3'b110, 32'h100, 1'b1, 2'b01);
    bad_op(ST, 3'b001, 32'h005, 1'b1, 2'b00);
    bad_op(LD, 3'b011, 32'h101, 1'b1, 2'b01);
    bad_op(7'b0110011, 3'b010, 32'h101, 1'b0, 2'b00);
    @(negedge clk);
    issue_valid = 1'b1; opcode = LD; funct3 = 3'b010; addr = 32'h200; bus.mem_ready_n = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_req_before", {31'b0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mid_stall", {31'b0, stall}, 32'd0);
    chk("rst_mid_done", {31'b0, done}, 32'd0);
    chk("rst_mid_load", load_data, 32'd0);
    rst = 1'b0;
    mem_op(LD, 3'b010, 32'h10C, 32'h0, 32'h01020304, 0, 4'b1111, 32'h0, 32'h01020304);
`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    issue_valid = 1'b1; opcode = LD; funct3 = 3'b010; addr = 32'h40; bus.mem_ready_n = 1'b1;
    bus.mem_rdata = 32'hBADBAD00;
    @(negedge clk);
    issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tmo_req", {31'b0, bus.mem_req}, 32'd1);
      @(negedge clk);
    end
    #1;
    chk("tmo_done", {31'b0, done}, 32'd1);
    chk("tmo_fault", {31'b0, fault}, 32'd1);
    chk("tmo_cause", {30'b0, fault_cause}, 32'd2);
    chk("tmo_noreq", {31'b0, bus.mem_req}, 32'd0);
    chk("tmo_load", load_data, 32'h01020304);
    @(negedge clk);
    #1;
    chk("tmo_after_fault", {31'b0, fault}, 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
